// File: rtl/water_supply_arbiter.sv
// Round-robin arbiter for one shared water inlet feeding four machines.
// A grant runs until fill success, request abort or timeout; a settle gap follows each release.
module water_supply_arbiter #(
    parameter logic [15:0] MAX_FILL_CYCLES = 16'd5000,
    parameter logic [3:0]  SETTLE_CYCLES   = 4'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] fill_req,
    input  logic [3:0] filled,
    input  logic [3:0] fault_clr,
    output logic [3:0] grant,
    output logic       valve_on,
    output logic [3:0] fill_ok,
    output logic [3:0] fault,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [1:0]  rr_ptr_r, rr_ptr_s;
    logic [1:0]  gidx_r, gidx_s;
    logic [15:0] fill_timer_r, fill_timer_s;
    logic [3:0]  settle_cnt_r, settle_cnt_s;
    logic [3:0]  eligible_s;
    logic [2:0]  pick_s;
    logic        pick_valid_s;
    logic [1:0]  pick_idx_s;
    logic        done_ok_s, done_abort_s, done_tmo_s, fill_exit_s;
    logic        settle_done_s;
    logic [3:0]  grant_s, fill_ok_s, fault_s;
    logic        valve_on_s, busy_s;

    // Lowest offset from ptr wins; the descending loop lets that candidate overwrite the others.
    function automatic logic [2:0] rr_pick(input logic [3:0] elig, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + i[1:0];
            if (elig[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign eligible_s    = fill_req & ~fault;
    assign pick_s        = rr_pick(eligible_s, rr_ptr_r);
    assign pick_valid_s  = pick_s[2];
    assign pick_idx_s    = pick_s[1:0];
    assign done_ok_s     = filled[gidx_r];
    assign done_abort_s  = ~fill_req[gidx_r];
    assign done_tmo_s    = (fill_timer_r == (MAX_FILL_CYCLES - 16'd1));
    assign fill_exit_s   = done_ok_s | done_abort_s | done_tmo_s;
    assign settle_done_s = (SETTLE_CYCLES == 4'd0) || (settle_cnt_r == (SETTLE_CYCLES - 4'd1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decision.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (fill_exit_s) begin
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_SETTLE: begin
                if (settle_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the datapath and of every registered output.
    always_comb begin
        rr_ptr_s     = rr_ptr_r;
        gidx_s       = gidx_r;
        fill_timer_s = fill_timer_r;
        settle_cnt_s = settle_cnt_r;
        grant_s      = 4'b0000;
        valve_on_s   = 1'b0;
        fill_ok_s    = 4'b0000;
        fault_s      = fault & ~fault_clr;
        busy_s       = (state_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    gidx_s       = pick_idx_s;
                    grant_s      = 4'b0001 << pick_idx_s;
                    valve_on_s   = 1'b1;
                    fill_timer_s = 16'd0;
                end else begin
                    gidx_s = gidx_r;
                end
            end
            ST_FILL: begin
                if (fill_exit_s) begin
                    rr_ptr_s          = gidx_r + 2'd1;
                    settle_cnt_s      = 4'd0;
                    fill_ok_s[gidx_r] = done_ok_s;
                    // Timeout is the lowest-priority exit; it also beats a same-cycle clear.
                    if (!done_ok_s && !done_abort_s) begin
                        fault_s[gidx_r] = 1'b1;
                    end else begin
                        fault_s[gidx_r] = fault_s[gidx_r];
                    end
                end else begin
                    grant_s    = grant;
                    valve_on_s = 1'b1;
                    if (fill_timer_r != 16'hFFFF) begin
                        fill_timer_s = fill_timer_r + 16'd1;
                    end else begin
                        fill_timer_s = fill_timer_r;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_done_s) begin
                    settle_cnt_s = 4'd0;
                end else begin
                    settle_cnt_s = settle_cnt_r + 4'd1;
                end
            end
            default: begin
                grant_s = 4'b0000;
            end
        endcase
    end

    // Datapath and output registers; reset closes the valve without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_r     <= 2'd0;
            gidx_r       <= 2'd0;
            fill_timer_r <= 16'd0;
            settle_cnt_r <= 4'd0;
            grant        <= 4'b0000;
            valve_on     <= 1'b0;
            fill_ok      <= 4'b0000;
            fault        <= 4'b0000;
            busy         <= 1'b0;
        end else begin
            rr_ptr_r     <= rr_ptr_s;
            gidx_r       <= gidx_s;
            fill_timer_r <= fill_timer_s;
            settle_cnt_r <= settle_cnt_s;
            grant        <= grant_s;
            valve_on     <= valve_on_s;
            fill_ok      <= fill_ok_s;
            fault        <= fault_s;
            busy         <= busy_s;
        end
    end

endmodule

// File: tb/tb_water_supply_arbiter.sv
// Directed bench: instance a uses default parameters, instance b a short fill timeout of 8 cycles.
module tb_water_supply_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] fill_req, filled, fault_clr;
    logic [3:0] grant_a, fill_ok_a, fault_a;
    logic       valve_a, busy_a;
    logic [3:0] grant_b, fill_ok_b, fault_b;
    logic       valve_b, busy_b;
    logic [3:0] exp_g;
    int         n_tests;
    int         n_fail;

    water_supply_arbiter u_dut_a (
        .clk(clk), .reset(reset), .fill_req(fill_req), .filled(filled), .fault_clr(fault_clr),
        .grant(grant_a), .valve_on(valve_a), .fill_ok(fill_ok_a), .fault(fault_a), .busy(busy_a)
    );

    water_supply_arbiter #(.MAX_FILL_CYCLES(16'd8), .SETTLE_CYCLES(4'd2)) u_dut_b (
        .clk(clk), .reset(reset), .fill_req(fill_req), .filled(filled), .fault_clr(fault_clr),
        .grant(grant_b), .valve_on(valve_b), .fill_ok(fill_ok_b), .fault(fault_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic check_a(input string tag, input logic [3:0] g, input logic v,
                           input logic [3:0] ok, input logic [3:0] f, input logic b);
        chk({tag, ".grant_a"}, grant_a, g);
        chk({tag, ".valve_a"}, {3'b000, valve_a}, {3'b000, v});
        chk({tag, ".fill_ok_a"}, fill_ok_a, ok);
        chk({tag, ".fault_a"}, fault_a, f);
        chk({tag, ".busy_a"}, {3'b000, busy_a}, {3'b000, b});
    endtask

    task automatic check_b(input string tag, input logic [3:0] g, input logic v,
                           input logic [3:0] ok, input logic [3:0] f, input logic b);
        chk({tag, ".grant_b"}, grant_b, g);
        chk({tag, ".valve_b"}, {3'b000, valve_b}, {3'b000, v});
        chk({tag, ".fill_ok_b"}, fill_ok_b, ok);
        chk({tag, ".fault_b"}, fault_b, f);
        chk({tag, ".busy_b"}, {3'b000, busy_b}, {3'b000, b});
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        fill_req  = 4'b0000;
        filled    = 4'b0000;
        fault_clr = 4'b0000;
        #1 reset = 1'b0;
        #1;
        check_a("reset", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        check_b("reset", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Single successful fill on machine 0, filled arriving 10 cycles into the grant.
        fill_req = 4'b0001;
        tick();
        check_a("fill_grant", 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b1);
        for (int i = 1; i < 10; i++) begin
            tick();
            chk("fill_hold", grant_a, 4'b0001);
        end
        filled = 4'b0001;
        tick();
        check_a("fill_done", 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b1);
        filled   = 4'b0000;
        fill_req = 4'b0000;
        tick();
        check_a("fill_settle2", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1);
        tick();
        check_a("fill_idle", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);

        // All four requesting: rotation and a 3-cycle gap between grants.
        pulse_reset();
        fill_req = 4'b1111;
        exp_g    = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_grant", grant_a, exp_g);
            tick();
            chk("rr_hold", grant_a, exp_g);
            tick();
            chk("rr_hold", grant_a, exp_g);
            filled = exp_g;
            tick();
            chk("rr_release", grant_a, 4'b0000);
            chk("rr_ok", fill_ok_a, exp_g);
            filled = 4'b0000;
            tick();
            chk("rr_gap", grant_a, 4'b0000);
            tick();
            chk("rr_gap", grant_a, 4'b0000);
            exp_g = {exp_g[2:0], exp_g[3]};
        end

        // Machine 1 aborts by dropping its request at cycle 5; the pointer moves to 2.
        fill_req = 4'b0010;
        tick();
        check_a("abort_grant", 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_hold", grant_a, 4'b0010);
        end
        fill_req = 4'b0000;
        tick();
        check_a("abort_rel", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1);
        fill_req = 4'b0111;
        tick();
        chk("abort_settle", grant_a, 4'b0000);
        tick();
        chk("abort_idle", grant_a, 4'b0000);
        tick();
        chk("abort_rrptr", grant_a, 4'b0100);
        fill_req = 4'b0000;
        repeat (3) tick();
        chk("abort_busy", {3'b000, busy_a}, 4'b0000);

        // Short-timeout instance: machine 2 times out after 8 granted cycles.
        pulse_reset();
        fill_req = 4'b0100;
        tick();
        check_b("tmo_grant", 4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("tmo_hold", grant_b, 4'b0100);
        end
        tick();
        check_b("tmo_fault", 4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b1);
        repeat (4) tick();
        check_b("tmo_masked", 4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b0);
        fill_req = 4'b0101;
        tick();
        check_b("tmo_other", 4'b0001, 1'b1, 4'b0000, 4'b0100, 1'b1);
        filled = 4'b0001;
        tick();
        check_b("tmo_other_ok", 4'b0000, 1'b0, 4'b0001, 4'b0100, 1'b1);
        filled   = 4'b0000;
        fill_req = 4'b0100;
        repeat (3) tick();
        chk("tmo_still_masked", grant_b, 4'b0000);
        fault_clr = 4'b0100;
        tick();
        check_b("tmo_clear", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        fault_clr = 4'b0000;
        tick();
        check_b("tmo_regrant", 4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b1);
        fill_req = 4'b0000;
        repeat (3) tick();

        // filled on the timeout cycle counts as success, not a fault.
        fill_req = 4'b1000;
        tick();
        chk("race_grant", grant_b, 4'b1000);
        repeat (7) tick();
        filled = 4'b1000;
        tick();
        check_b("race_ok", 4'b0000, 1'b0, 4'b1000, 4'b0000, 1'b1);
        filled   = 4'b0000;
        fill_req = 4'b0000;
        repeat (2) tick();

        // Timeout set and clear on the same bit in the same cycle leaves the fault set.
        fill_req = 4'b0001;
        tick();
        chk("setclr_grant", grant_b, 4'b0001);
        repeat (7) tick();
        fault_clr = 4'b0001;
        tick();
        check_b("setclr_fault", 4'b0000, 1'b0, 4'b0000, 4'b0001, 1'b1);
        fault_clr = 4'b0000;

        // Asynchronous reset in the middle of a fill, then arbitration restarts at machine 0.
        fill_req = 4'b0010;
        repeat (3) tick();
        chk("arst_grant", grant_b, 4'b0010);
        tick();
        reset = 1'b0;
        #1;
        check_b("arst_async", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        chk("arst_async_a", grant_a, 4'b0000);
        fill_req = 4'b1010;
        reset    = 1'b1;
        tick();
        check_b("arst_first", 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b1);
        chk("arst_first_a", grant_a, 4'b0010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/water_supply_arbiter.md
WATER_SUPPLY_ARBITER -- requirements
Module: water_supply_arbiter

Interface
REQ-001 SHALL have parameter MAX_FILL_CYCLES, default 16'd5000, meaning the fill-timeout limit in clk cycles (range 2..65535).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4'd2, meaning the valve settle gap in clk cycles after each release (range 0..15).
REQ-003 SHALL have port clk, input, 1 bit: system clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port fill_req, input, 4 bits: level request for water, one bit per machine.
REQ-006 SHALL have port filled, input, 4 bits: per-machine drum-full level sensor.
REQ-007 SHALL have port fault_clr, input, 4 bits: per-machine fault clear, sampled each cycle.
REQ-008 SHALL have port grant, output, 4 bits: one-hot (or zero) grant of the shared inlet.
REQ-009 SHALL have port valve_on, output, 1 bit: main supply valve open.
REQ-010 SHALL have port fill_ok, output, 4 bits: one-cycle pulse for a successful fill, per machine.
REQ-011 SHALL have port fault, output, 4 bits: sticky fill-timeout fault flag, per machine.
REQ-012 SHALL have port busy, output, 1 bit: high when the FSM is not in IDLE.

Function
REQ-013 SHALL register all outputs, with no combinational input-to-output path.
REQ-014 SHALL implement FSM states IDLE, FILL and SETTLE.
REQ-015 SHALL form the eligible set as fill_req & ~fault.
REQ-016 SHALL, in IDLE with a non-empty eligible set, select the first eligible machine searching upward from rr_ptr with modulo-4 wrap.
REQ-017 SHALL, on that IDLE selection, enter FILL on the next edge with grant one-hot for the selection, valve_on=1 and fill_timer=0.
REQ-018 SHALL give one-cycle latency from an eligible request in IDLE to the grant.
REQ-019 SHALL, in FILL, increment fill_timer by 1 each cycle; the timer is 16 bits and never wraps.
REQ-020 SHALL evaluate the FILL exit conditions for granted machine g in this priority order: filled[g]=1 means success; else fill_req[g]=0 means abort; else fill_timer==MAX_FILL_CYCLES-1 means timeout.
REQ-021 SHALL, on success, pulse fill_ok[g] high for exactly one cycle, coincident with the first cycle of SETTLE.
REQ-022 SHALL, on timeout, set fault[g]=1 in the first SETTLE cycle, after MAX_FILL_CYCLES cycles of grant.
REQ-023 SHALL, on abort, assert neither fill_ok nor fault.
REQ-024 SHALL, on any FILL exit, move to SETTLE on the next edge with grant=0 and valve_on=0, and set rr_ptr=(g+1) mod 4.
REQ-025 SHALL remain in SETTLE for SETTLE_CYCLES cycles and then enter IDLE; with SETTLE_CYCLES=0 it enters IDLE after one cycle.
REQ-026 SHALL keep grant low for at least SETTLE_CYCLES+1 cycles between consecutive grants (minimum 2 cycles when SETTLE_CYCLES=0).
REQ-027 SHALL ignore changes in fill_req of non-granted machines during FILL and SETTLE; re-evaluation happens only in IDLE.
REQ-028 SHALL clear fault[i] when fault_clr[i]=1; a simultaneous timeout set and clear on the same bit resolves to set.
REQ-029 SHALL, for a faulted machine, keep its request masked until the fault is cleared, while other machines continue to be arbitrated.
REQ-030 SHALL ignore filled bits of non-granted machines.
REQ-031 SHALL keep IDLE, with grant=0 and valve_on=0, while all machines are faulted or none request.
REQ-032 SHALL guarantee that grant is never multi-hot and that valve_on equals |grant in every cycle.

Reset
REQ-033 SHALL, while reset=0, force immediately (asynchronously) state=IDLE, grant=0, valve_on=0, fill_ok=0, fault=0, busy=0, rr_ptr=0, fill_timer=0 and settle counter=0.
REQ-034 SHALL, on reset assertion mid-FILL, close the valve immediately without fill_ok or fault, and start the first post-reset search at machine 0.
REQ-035 SHALL resume arbitration on the first rising clk edge after reset returns to 1.

Verification
REQ-036 SHALL cover: after reset, fill_req=4'b0001, filled[0] rises 10 cycles after grant -> grant=0001 one cycle after req, fill_ok=0001 pulse once, valve_on low during 2 SETTLE cycles.
REQ-037 SHALL cover: fill_req=4'b1111 held, filled asserted 3 cycles into each grant -> grant order 0001,0010,0100,1000,0001, with a gap of 3 cycles between grants.
REQ-038 SHALL cover: MAX_FILL_CYCLES=8, fill_req=4'b0100 with filled never set -> grant held 8 cycles, fault=0100, subsequent requests from machine 2 ignored, fault_clr[2] pulse -> fault=0000 and machine 2 granted again.
REQ-039 SHALL cover: machine 1 granted, fill_req[1] dropped at cycle 5 -> release with no fill_ok and no fault, rr_ptr=2.
REQ-040 SHALL cover: filled[g] and timeout in the same cycle -> fill_ok pulse and fault unchanged; timeout set coincident with fault_clr -> fault bit = 1.
REQ-041 SHALL cover: reset=0 mid-FILL -> grant, valve_on and busy go 0 without waiting for a clock edge; after release with fill_req=4'b1010, grant=0010 first.
